// File: rtl/instr_fetch_buffer.sv
// -----------------------------------------------------------------------------
// instr_fetch_buffer
//
// Instruction memory with a sequential prefetch engine and a small output FIFO.
// Program words are written through the load port while the unit is idle.
// A jump starts (or redirects) fetching at jump_addr. Words at consecutive
// addresses are then streamed to the decode stage over a valid/ready
// handshake. A fetch address past the end of memory stops the engine in FAULT.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   load_en/addr/data program load port (honoured only in IDLE, in range)
//   jump_valid/addr   start or redirect fetching; flushes buffered words
//   halt              flush and return to IDLE (wins over jump_valid)
//   instr_valid/ready handshake for the FIFO head
//   instr_data/pc     head instruction and its address
//   busy              engine is in FETCH
//   fault             engine stopped on an out-of-range fetch address
// -----------------------------------------------------------------------------
module instr_fetch_buffer #(
    parameter int DATA_WIDTH = 20,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  jump_valid,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    input  logic                  halt,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  busy,
    output logic                  fault
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // One extra bit so DEPTH == 2^ADDR_WIDTH is representable; then every pc
    // is in range and the address simply wraps.
    localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_W:0]      FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_FAULT
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] rd_pc_q, rd_pc_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]        count_q, count_d;

    logic [DATA_WIDTH-1:0] mem       [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];

    logic                  flush;
    logic                  pc_in_range;
    logic                  load_ok;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [PTR_W:0]        fill;

    // Outputs are masked by valid so the un-reset FIFO storage never leaks out.
    assign instr_valid = (count_q != '0);
    assign instr_data  = instr_valid ? fifo_data[rd_ptr_q] : '0;
    assign instr_pc    = instr_valid ? fifo_pc[rd_ptr_q]   : '0;
    assign busy        = (state_q == S_FETCH);
    assign fault       = (state_q == S_FAULT);

    // NOTE: every signal assigned in always_comb gets a default first; a
    // missing default on any path would infer a latch.
    always_comb begin
        flush       = halt | jump_valid;
        pc_in_range = ({1'b0, pc_q} < DEPTH_W);
        load_ok     = (state_q == S_IDLE) && load_en
                      && ({1'b0, load_addr} < DEPTH_W);
        // Occupancy is the pre-pop value, so a full FIFO only reopens issue
        // the cycle after a pop has actually happened.
        fill        = count_q + (PTR_W+1)'(inflight_q);
        issue       = (state_q == S_FETCH) && !flush && pc_in_range
                      && (fill < FIFO_FULL);
        push        = inflight_q && !flush;
        pop         = instr_valid && instr_ready && !flush;

        state_d    = state_q;
        pc_d       = pc_q;
        inflight_d = issue;
        rd_pc_d    = issue ? pc_q : rd_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (halt) begin
            state_d = S_IDLE;
        end else if (jump_valid) begin
            state_d = S_FETCH;
            pc_d    = jump_addr;
        end else if (state_q == S_FETCH) begin
            if (!pc_in_range) begin
                state_d = S_FAULT;
            end else if (issue) begin
                pc_d = pc_q + ADDR_WIDTH'(1);
            end
        end

        if (flush) begin
            // A same-cycle pop is treated as consumed and a returning read is
            // dropped; both vanish with the pointer reset.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            inflight_q <= 1'b0;
            rd_pc_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            rd_pc_q    <= rd_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: storage arrays carry no reset so they map onto RAM; program
    // contents survive rst_n, and FIFO slots are qualified by count_q.
    // Loads happen only in IDLE and reads only in FETCH, so they never collide.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[load_addr[IDX_W-1:0]] <= load_data;
        end
        if (issue) begin
            rd_data_q <= mem[pc_q[IDX_W-1:0]];
        end
        if (push) begin
            fifo_data[wr_ptr_q] <= rd_data_q;
            fifo_pc[wr_ptr_q]   <= rd_pc_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_buffer
//
// Directed bench for instr_fetch_buffer with default parameters
// (DATA_WIDTH=20, ADDR_WIDTH=16, DEPTH=128, FIFO_DEPTH=4).
// Inputs are driven and outputs sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch_buffer;

    localparam int DW = 20;
    localparam int AW = 16;
    localparam int DEPTH = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          jump_valid;
    logic [AW-1:0] jump_addr;
    logic          halt;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr_data;
    logic [AW-1:0] instr_pc;
    logic          busy;
    logic          fault;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] model_mem [DEPTH];

    instr_fetch_buffer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .jump_valid  (jump_valid),
        .jump_addr   (jump_addr),
        .halt        (halt),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .busy        (busy),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_jump(input logic [AW-1:0] addr);
        jump_valid = 1'b1;
        jump_addr  = addr;
        step();
        jump_valid = 1'b0;
    endtask

    task automatic do_halt();
        halt = 1'b1;
        step();
        halt = 1'b0;
    endtask

    task automatic expect_instr(input string tag, input int pc);
        check({tag, ".valid"}, 32'(instr_valid), 32'd1);
        check({tag, ".pc"},    32'(instr_pc),    32'(pc));
        check({tag, ".data"},  32'(instr_data),  32'(model_mem[pc]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        load_en     = 1'b0;
        load_addr   = '0;
        load_data   = '0;
        jump_valid  = 1'b0;
        jump_addr   = '0;
        halt        = 1'b0;
        instr_ready = 1'b0;

        // Reset values
        #3;
        check("rst.valid", 32'(instr_valid), 32'd0);
        check("rst.busy",  32'(busy),        32'd0);
        check("rst.fault", 32'(fault),       32'd0);
        check("rst.data",  32'(instr_data),  32'd0);
        check("rst.pc",    32'(instr_pc),    32'd0);
        #10 rst_n = 1'b1;
        step();

        // Program load: mem[0..7] = 1..8, the rest tagged with their address
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = (i < 8) ? DW'(i + 1) : (20'hA0000 | DW'(i));
            load_en   = 1'b1;
            load_addr = AW'(i);
            load_data = model_mem[i];
            step();
        end
        load_en = 1'b0;
        check("idle.busy", 32'(busy), 32'd0);

        // Streaming from 0: valid first high two cycles after the jump edge
        instr_ready = 1'b1;
        do_jump(16'd0);
        check("s1.busy",    32'(busy),        32'd1);
        check("s1.valid_a", 32'(instr_valid), 32'd0);
        step();
        check("s1.valid_b", 32'(instr_valid), 32'd0);
        step();
        expect_instr("s1.first", 0);
        for (int k = 1; k < 8; k++) begin
            step();
            expect_instr($sformatf("s1.pc%0d", k), k);
        end
        do_halt();
        check("halt.valid", 32'(instr_valid), 32'd0);
        check("halt.busy",  32'(busy),        32'd0);

        // Backpressure: buffer fills, head held stable, then drains gap-free
        instr_ready = 1'b0;
        do_jump(16'd0);
        for (int k = 0; k < 10; k++) step();
        expect_instr("bp.held", 0);
        step();
        expect_instr("bp.stable", 0);
        instr_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            expect_instr($sformatf("bp.pc%0d", k), k);
            step();
        end
        do_halt();

        // Fault at the end of memory
        do_jump(16'd126);
        step();
        step();
        expect_instr("flt.126", 126);
        check("flt.fault_a", 32'(fault), 32'd0);
        step();
        expect_instr("flt.127", 127);
        check("flt.fault_b", 32'(fault), 32'd1);
        check("flt.busy",    32'(busy),  32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("flt.novalid%0d", k), 32'(instr_valid), 32'd0);
        end
        do_jump(16'd5);
        check("flt.clear", 32'(fault), 32'd0);
        check("flt.rebusy", 32'(busy), 32'd1);
        step();
        step();
        expect_instr("flt.pc5", 5);

        // Redirect while the buffer holds 10-12 and 13 is in flight
        instr_ready = 1'b0;
        do_jump(16'd10);
        for (int k = 0; k < 4; k++) step();
        expect_instr("rd.head10", 10);
        jump_valid  = 1'b1;
        jump_addr   = 16'd40;
        instr_ready = 1'b1;
        step();
        jump_valid = 1'b0;
        check("rd.flush_a", 32'(instr_valid), 32'd0);
        step();
        check("rd.flush_b", 32'(instr_valid), 32'd0);
        step();
        expect_instr("rd.pc40", 40);
        step();
        expect_instr("rd.pc41", 41);

        // halt wins over a simultaneous jump
        jump_valid = 1'b1;
        jump_addr  = 16'd3;
        halt       = 1'b1;
        step();
        jump_valid = 1'b0;
        halt       = 1'b0;
        check("hj.busy",  32'(busy),        32'd0);
        check("hj.valid", 32'(instr_valid), 32'd0);
        check("hj.fault", 32'(fault),       32'd0);
        step();
        check("hj.valid2", 32'(instr_valid), 32'd0);

        // Load while fetching must not modify memory
        instr_ready = 1'b0;
        do_jump(16'd0);
        load_en   = 1'b1;
        load_addr = 16'd2;
        load_data = 20'hFFFFF;
        step();
        load_en = 1'b0;
        do_halt();
        instr_ready = 1'b1;
        do_jump(16'd0);
        step();
        step();
        expect_instr("ld.pc0", 0);
        step();
        expect_instr("ld.pc1", 1);
        step();
        expect_instr("ld.pc2", 2);

        // Asynchronous reset mid-burst
        step();
        #3 rst_n = 1'b0;
        #1;
        check("ar.valid", 32'(instr_valid), 32'd0);
        check("ar.busy",  32'(busy),        32'd0);
        check("ar.fault", 32'(fault),       32'd0);
        check("ar.data",  32'(instr_data),  32'd0);
        check("ar.pc",    32'(instr_pc),    32'd0);
        #2 rst_n = 1'b1;
        step();
        step();
        check("ar.idle_valid", 32'(instr_valid), 32'd0);
        check("ar.idle_busy",  32'(busy),        32'd0);
        do_jump(16'd4);
        step();
        step();
        expect_instr("ar.pc4", 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
